fu_issue: RTL and testbench
===========================

// Module: fu_issue
// PURPOSE
//   Issue/writeback stage directly upstream of the fu functional unit.
//   - Accepts register-addressed instructions over a valid/ready handshake.
//   - Reads operands from an internal register file and drives op/data_a/data_b into fu.
//   - Writes fu's registered result F and flags {Z,N,C,V} back to the register file.
//   - Stalls on read-after-write hazards against in-flight results.
// PARAMETERS
//   DSIZE   16  data width; matches fu
//   OPSIZE  5   opcode width; matches fu; passed through uninterpreted
//   RSIZE   3   register address width (2**RSIZE registers)
//   FU_LAT  1   fu result latency in clk edges after op/data are presented (>=1)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       synchronous reset, active-high
//   ins_valid_i    in   1       instruction valid
//   ins_ready_o    out  1       instruction accepted when valid&ready at clk edge
//   ins_op_i       in   OPSIZE  opcode
//   ins_rd_i       in   RSIZE   destination register
//   ins_ra_i       in   RSIZE   source register for data_a
//   ins_rb_i       in   RSIZE   source register for data_b
//   op_o           out  OPSIZE  to fu.op
//   data_a_o       out  DSIZE   to fu.data_a
//   data_b_o       out  DSIZE   to fu.data_b
//   issue_o        out  1       op_o/data_*_o carry a newly issued instruction this cycle
//   F_i            in   DSIZE   from fu.F_o
//   Z_i,N_i,C_i,V_i in  1 each  from fu flag outputs
//   flags_o        out  4       architectural flags {Z,N,C,V}
//   busy_o         out  1       any instruction in flight
//   dbg_addr_i     in   RSIZE   register-file debug read address
//   dbg_data_o     out  DSIZE   rf[dbg_addr_i], combinational
// BEHAVIOUR
//   Reset (rst=1 at edge): all rf entries=0, op_o=0, data_a_o=0, data_b_o=0, issue_o=0,
//     flags_o=0, pending chain cleared, busy_o=0; ins_ready_o=0 while rst=1.
//     Reset mid-operation discards every in-flight result; no writeback follows.
//   Register file: 2**RSIZE x DSIZE. r0 reads 0 always; writes to r0 are discarded,
//     but flags are still updated.
//   Pending chain: FU_LAT+1 stages, each {valid, rd}; shifts every edge.
//     Stage 0 is loaded on accept; otherwise stage 0 is loaded invalid.
//   Hazard: hz=1 if any valid stage has rd!=0 and rd==ins_ra_i or rd==ins_rb_i.
//   ins_ready_o = !rst & !hz (combinational). No operand bypass; the stall covers
//     the writeback cycle.
//   Accept at edge t: op_o<=ins_op_i; data_a_o<=rf[ra]; data_b_o<=rf[rb]; issue_o<=1.
//     Without an accept: op/data hold their last values and issue_o<=0.
//   fu registers the result at edge t+FU_LAT.
//   Writeback at edge t+FU_LAT+1, while the last stage is valid:
//     rf[rd]<=F_i; flags_o<={Z_i,N_i,C_i,V_i}.
//   Back-to-back independent instructions issue one per cycle. A dependent instruction
//     is accepted at the first edge after the writeback edge, so it reads the new value.
//   A write and an accept on the same edge are legal (independent registers).
//   busy_o = OR of all pending-stage valid bits.
//   op is never decoded here; fu interprets it.
// TESTING
//   Bench models fu: registered, F=data_a+data_b, flags derived from F; FU_LAT=1.
//   1 Reset: preload nothing, rst 2 cycles -> all outputs 0, dbg_data_o=0 for every addr,
//     ins_ready_o=0 during rst.
//   2 Issue r1=r0+r0 and check rd=1 writeback, then a bench-forced F_i=16'h1234
//     (the model is overridden for that one cycle) -> dbg rf[1]=16'h1234 exactly
//     2 edges after accept; flags_o updated.
//   3 RAW: accept rd=2 (result 16'h0005), next cycle present ra=2 -> ins_ready_o=0
//     for 2 cycles; the instruction then issues with data_a_o=16'h0005.
//   4 Independent stream of 4 instructions with distinct rd/ra/rb -> issue_o high
//     4 consecutive cycles, 4 writebacks on consecutive edges.
//   5 Write to r0 with F_i=16'hFFFF, N=1 -> rf[0] still reads 0; flags_o=4'b0100;
//     ra=0 never stalls.
//   6 rst asserted 1 cycle after accept -> no writeback to rd; busy_o=0; rf all 0.

Source files
------------

// File: rtl/fu_issue.sv
// ============================================================================
//  Module   : fu_issue
//  Purpose  : Issue/writeback stage feeding the fu functional unit; register
//             file, RAW stall against in-flight results, result writeback.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_issue #(
    parameter int DSIZE  = 16,
    parameter int OPSIZE = 5,
    parameter int RSIZE  = 3,
    parameter int FU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid_i,
    output logic              ins_ready_o,
    input  logic [OPSIZE-1:0] ins_op_i,
    input  logic [RSIZE-1:0]  ins_rd_i,
    input  logic [RSIZE-1:0]  ins_ra_i,
    input  logic [RSIZE-1:0]  ins_rb_i,
    output logic [OPSIZE-1:0] op_o,
    output logic [DSIZE-1:0]  data_a_o,
    output logic [DSIZE-1:0]  data_b_o,
    output logic              issue_o,
    input  logic [DSIZE-1:0]  F_i,
    input  logic              Z_i,
    input  logic              N_i,
    input  logic              C_i,
    input  logic              V_i,
    output logic [3:0]        flags_o,
    output logic              busy_o,
    input  logic [RSIZE-1:0]  dbg_addr_i,
    output logic [DSIZE-1:0]  dbg_data_o
);

    localparam int c_NREG = 1 << RSIZE;
    localparam int c_NSTG = FU_LAT + 1;

    logic [DSIZE-1:0]  rf_q [c_NREG];
    logic [DSIZE-1:0]  rf_d [c_NREG];
    logic [OPSIZE-1:0] op_q, op_d;
    logic [DSIZE-1:0]  data_a_q, data_a_d;
    logic [DSIZE-1:0]  data_b_q, data_b_d;
    logic              issue_q, issue_d;
    logic [3:0]        flags_q, flags_d;
    logic [c_NSTG-1:0] pv_q, pv_d;
    logic [RSIZE-1:0]  prd_q [c_NSTG];
    logic [RSIZE-1:0]  prd_d [c_NSTG];

    logic w_hz;
    logic w_accept;
    logic w_wb;

    // r0 is a constant zero, so it can never be a true dependency.
    always_comb begin
        w_hz = 1'b0;
        for (int i = 0; i < c_NSTG; i++) begin
            if (pv_q[i] && (prd_q[i] != '0) &&
                ((prd_q[i] == ins_ra_i) || (prd_q[i] == ins_rb_i))) begin
                w_hz = 1'b1;
            end
        end
    end

    assign ins_ready_o = !rst && !w_hz;
    assign w_accept    = ins_valid_i && ins_ready_o;
    assign w_wb        = pv_q[c_NSTG-1];

    always_comb begin
        pv_d[0]  = w_accept;
        prd_d[0] = ins_rd_i;
        for (int i = 1; i < c_NSTG; i++) begin
            pv_d[i]  = pv_q[i-1];
            prd_d[i] = prd_q[i-1];
        end
    end

    // Operands read the pre-writeback value; the stall guarantees no RAW overlap.
    always_comb begin
        op_d     = op_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        issue_d  = w_accept;
        flags_d  = flags_q;
        for (int i = 0; i < c_NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (w_accept) begin
            op_d     = ins_op_i;
            data_a_d = rf_q[ins_ra_i];
            data_b_d = rf_q[ins_rb_i];
        end
        if (w_wb) begin
            flags_d = {Z_i, N_i, C_i, V_i};
            if (prd_q[c_NSTG-1] != '0) begin
                rf_d[prd_q[c_NSTG-1]] = F_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            issue_q  <= 1'b0;
            flags_q  <= '0;
            pv_q     <= '0;
            for (int i = 0; i < c_NSTG; i++) begin
                prd_q[i] <= '0;
            end
            for (int i = 0; i < c_NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            op_q     <= op_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            issue_q  <= issue_d;
            flags_q  <= flags_d;
            pv_q     <= pv_d;
            for (int i = 0; i < c_NSTG; i++) begin
                prd_q[i] <= prd_d[i];
            end
            for (int i = 0; i < c_NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign op_o       = op_q;
    assign data_a_o   = data_a_q;
    assign data_b_o   = data_b_q;
    assign issue_o    = issue_q;
    assign flags_o    = flags_q;
    assign busy_o     = |pv_q;
    assign dbg_data_o = rf_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: tb/tb_fu_issue.sv
// ============================================================================
//  Module   : tb_fu_issue
//  Purpose  : Directed self-checking bench for fu_issue with a registered
//             adder standing in for fu.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid_i;
    logic        ins_ready_o;
    logic [4:0]  ins_op_i;
    logic [2:0]  ins_rd_i, ins_ra_i, ins_rb_i;
    logic [4:0]  op_o;
    logic [15:0] data_a_o, data_b_o;
    logic        issue_o;
    logic [15:0] F_i;
    logic        Z_i, N_i, C_i, V_i;
    logic [3:0]  flags_o;
    logic        busy_o;
    logic [2:0]  dbg_addr_i;
    logic [15:0] dbg_data_o;

    int total = 0;
    int bad   = 0;

    // fu model: registered adder; may be overridden for one writeback
    logic [15:0] fu_f;
    logic        fu_c, fu_v;
    logic [16:0] fu_sum;
    logic        force_en = 1'b0;
    logic [15:0] force_f  = '0;
    logic [3:0]  force_fl = '0;

    assign fu_sum = {1'b0, data_a_o} + {1'b0, data_b_o};
    always_ff @(posedge clk) begin
        fu_f <= fu_sum[15:0];
        fu_c <= fu_sum[16];
        fu_v <= (data_a_o[15] == data_b_o[15]) && (fu_sum[15] != data_a_o[15]);
    end
    assign F_i              = force_en ? force_f  : fu_f;
    assign {Z_i, N_i, C_i, V_i} = force_en ? force_fl : {(fu_f == 16'h0), fu_f[15], fu_c, fu_v};

    always #10 clk = ~clk;

    fu_issue #(.DSIZE(16), .OPSIZE(5), .RSIZE(3), .FU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o),
        .ins_op_i(ins_op_i), .ins_rd_i(ins_rd_i), .ins_ra_i(ins_ra_i), .ins_rb_i(ins_rb_i),
        .op_o(op_o), .data_a_o(data_a_o), .data_b_o(data_b_o), .issue_o(issue_o),
        .F_i(F_i), .Z_i(Z_i), .N_i(N_i), .C_i(C_i), .V_i(V_i),
        .flags_o(flags_o), .busy_o(busy_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [4:0] op, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb);
        ins_valid_i = v; ins_op_i = op; ins_rd_i = rd; ins_ra_i = ra; ins_rb_i = rb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_ins(1'b1, 5'h00, 3'd1, 3'd0, 3'd0);
        dbg_addr_i = 3'd0;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (ins_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready got %b exp 0", ins_ready_o); end
            total++; if ({op_o, data_a_o, data_b_o, issue_o} !== '0) begin bad++; $display("FAIL rst_datapath got op=%h a=%h b=%h iss=%b exp 0", op_o, data_a_o, data_b_o, issue_o); end
            total++; if ({flags_o, busy_o} !== 5'b0) begin bad++; $display("FAIL rst_flags_busy got flags=%b busy=%b exp 0", flags_o, busy_o); end
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr_i = 3'(a); #1;
            total++; if (dbg_data_o !== 16'h0) begin bad++; $display("FAIL rst_rf[%0d] got %h exp 0000", a, dbg_data_o); end
        end
        rst = 1'b0;
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        #1;
        total++; if (ins_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got %b exp 1", ins_ready_o); end
    endtask

    task automatic test_issue_wb();
        set_ins(1'b1, 5'h01, 3'd1, 3'd0, 3'd0);
        tick();
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        total++; if ({issue_o, op_o, data_a_o, data_b_o} !== {1'b1, 5'h01, 16'h0, 16'h0}) begin bad++; $display("FAIL wb_issue got iss=%b op=%h a=%h b=%h exp 1/01/0000/0000", issue_o, op_o, data_a_o, data_b_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL wb_busy got %b exp 1", busy_o); end
        tick();
        force_en = 1'b1; force_f = 16'h1234; force_fl = 4'b0011;
        dbg_addr_i = 3'd1; #1;
        total++; if (dbg_data_o !== 16'h0000) begin bad++; $display("FAIL wb_early got %h exp 0000", dbg_data_o); end
        total++; if (issue_o !== 1'b0) begin bad++; $display("FAIL wb_issue_drop got %b exp 0", issue_o); end
        tick();
        force_en = 1'b0; #1;
        total++; if (dbg_data_o !== 16'h1234) begin bad++; $display("FAIL wb_r1 got %h exp 1234", dbg_data_o); end
        total++; if (flags_o !== 4'b0011) begin bad++; $display("FAIL wb_flags got %b exp 0011", flags_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL wb_idle got %b exp 0", busy_o); end
    endtask

    task automatic test_raw();
        set_ins(1'b1, 5'h02, 3'd2, 3'd1, 3'd1);
        tick();
        total++; if (data_a_o !== 16'h1234) begin bad++; $display("FAIL raw_src got %h exp 1234", data_a_o); end
        set_ins(1'b1, 5'h03, 3'd3, 3'd2, 3'd0);
        #1;
        total++; if (ins_ready_o !== 1'b0) begin bad++; $display("FAIL raw_stall1 got %b exp 0", ins_ready_o); end
        tick();
        force_en = 1'b1; force_f = 16'h0005; force_fl = 4'b0000;
        total++; if ({ins_ready_o, issue_o} !== 2'b00) begin bad++; $display("FAIL raw_stall2 got rdy=%b iss=%b exp 0/0", ins_ready_o, issue_o); end
        tick();
        force_en = 1'b0;
        dbg_addr_i = 3'd2; #1;
        total++; if ({ins_ready_o, issue_o} !== 2'b10) begin bad++; $display("FAIL raw_release got rdy=%b iss=%b exp 1/0", ins_ready_o, issue_o); end
        total++; if (dbg_data_o !== 16'h0005) begin bad++; $display("FAIL raw_r2 got %h exp 0005", dbg_data_o); end
        tick();
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        total++; if ({issue_o, op_o, data_a_o, data_b_o} !== {1'b1, 5'h03, 16'h0005, 16'h0000}) begin bad++; $display("FAIL raw_issue got iss=%b op=%h a=%h b=%h exp 1/03/0005/0000", issue_o, op_o, data_a_o, data_b_o); end
        tick();
        tick();
        dbg_addr_i = 3'd3; #1;
        total++; if (dbg_data_o !== 16'h0005) begin bad++; $display("FAIL raw_r3 got %h exp 0005", dbg_data_o); end
        total++; if (flags_o !== 4'b0000) begin bad++; $display("FAIL raw_flags got %b exp 0000", flags_o); end
    endtask

    task automatic test_back_to_back();
        // r1=1234 r2=0005 r3=0005
        logic [2:0]  rd_t [4] = '{3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0]  ra_t [4] = '{3'd1, 3'd2, 3'd1, 3'd1};
        logic [2:0]  rb_t [4] = '{3'd2, 3'd3, 3'd0, 3'd1};
        logic [15:0] a_t  [4] = '{16'h1234, 16'h0005, 16'h1234, 16'h1234};
        logic [15:0] b_t  [4] = '{16'h0005, 16'h0005, 16'h0000, 16'h1234};
        logic [15:0] r_t  [4] = '{16'h1239, 16'h000A, 16'h1234, 16'h2468};
        for (int k = 0; k < 4; k++) begin
            set_ins(1'b1, 5'(8 + k), rd_t[k], ra_t[k], rb_t[k]);
            #1;
            total++; if (ins_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got %b exp 1", k, ins_ready_o); end
            tick();
            total++; if ({issue_o, data_a_o, data_b_o} !== {1'b1, a_t[k], b_t[k]}) begin bad++; $display("FAIL b2b_issue%0d got iss=%b a=%h b=%h exp 1/%h/%h", k, issue_o, data_a_o, data_b_o, a_t[k], b_t[k]); end
        end
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) tick();
            dbg_addr_i = rd_t[k]; #1;
            total++; if (dbg_data_o !== r_t[k]) begin bad++; $display("FAIL b2b_wb%0d got %h exp %h", k, dbg_data_o, r_t[k]); end
            if (k < 3) begin
                dbg_addr_i = rd_t[k+1]; #1;
                if (k >= 1) begin
                    total++; if (dbg_data_o !== 16'h0000) begin bad++; $display("FAIL b2b_early%0d got %h exp 0000", k + 1, dbg_data_o); end
                end
            end
        end
        total++; if ({flags_o, busy_o} !== 5'b0) begin bad++; $display("FAIL b2b_end got flags=%b busy=%b exp 0000/0", flags_o, busy_o); end
    endtask

    task automatic test_r0();
        set_ins(1'b1, 5'h04, 3'd0, 3'd1, 3'd2);
        tick();
        set_ins(1'b1, 5'h05, 3'd1, 3'd0, 3'd0);
        #1;
        total++; if (ins_ready_o !== 1'b1) begin bad++; $display("FAIL r0_nostall got %b exp 1", ins_ready_o); end
        tick();
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        force_en = 1'b1; force_f = 16'hFFFF; force_fl = 4'b0100;
        total++; if (issue_o !== 1'b1) begin bad++; $display("FAIL r0_issue got %b exp 1", issue_o); end
        tick();
        force_en = 1'b0;
        dbg_addr_i = 3'd0; #1;
        total++; if (dbg_data_o !== 16'h0000) begin bad++; $display("FAIL r0_zero got %h exp 0000", dbg_data_o); end
        total++; if (flags_o !== 4'b0100) begin bad++; $display("FAIL r0_flags got %b exp 0100", flags_o); end
        tick();
        dbg_addr_i = 3'd1; #1;
        total++; if ({dbg_data_o, flags_o} !== {16'h0000, 4'b1000}) begin bad++; $display("FAIL r0_follow got r1=%h flags=%b exp 0000/1000", dbg_data_o, flags_o); end
    endtask

    task automatic test_reset_mid();
        set_ins(1'b1, 5'h06, 3'd4, 3'd2, 3'd3);
        tick();
        set_ins(1'b0, 5'h00, 3'd0, 3'd0, 3'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({busy_o, issue_o} !== 2'b00) begin bad++; $display("FAIL mid_busy got busy=%b iss=%b exp 0/0", busy_o, issue_o); end
        tick();
        total++; if ({flags_o, busy_o} !== 5'b0) begin bad++; $display("FAIL mid_flags got flags=%b busy=%b exp 0000/0", flags_o, busy_o); end
        for (int a = 0; a < 8; a++) begin
            dbg_addr_i = 3'(a); #1;
            total++; if (dbg_data_o !== 16'h0) begin bad++; $display("FAIL mid_rf[%0d] got %h exp 0000", a, dbg_data_o); end
        end
    endtask

    initial begin
        test_reset();
        test_issue_wb();
        test_raw();
        test_back_to_back();
        test_r0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
